decoder_nto2n_scan: RTL and testbench



---
 rtl/decoder_pkg.sv | 26 ++
 rtl/scan_prescaler.sv | 36 +++
 rtl/decoder_nto2n_scan.sv | 83 ++++++++
 tb/tb_decoder_nto2n_scan.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the registered N-to-2^N decoder family: mode codes,
// counter sizing and the 138-style decode used by both clocked and combinational models.
package decoder_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Widest select supported by the shared decode function.
   localparam int MAX_N    = 10;
   localparam int MAX_OUTS = 1 << MAX_N;

   // Counter width for a modulo-div count; never narrower than one bit.
   function automatic int cnt_width(input int unsigned div);
      return (div <= 1) ? 1 : $clog2(div);
   endfunction

   // One line selected when enabled, otherwise every line inactive; callers slice to 2^N.
   function automatic logic [MAX_OUTS-1:0] decode(input int unsigned index,
                                                  input logic        en,
                                                  input logic        active_low);
      logic [MAX_OUTS-1:0] onehot;
      onehot = en ? (MAX_OUTS'(1) << index) : '0;
      return active_low ? ~onehot : onehot;
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running modulo-DIV prescaler: tick is high on the cycle the count sits at DIV-1
// while running; clr forces the count back to zero and wins over run.
module scan_prescaler
   import decoder_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic run,
   output logic tick
);

   localparam int           W        = cnt_width(DIV);
   localparam logic [W-1:0] TERMINAL = W'(DIV - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign tick = run && (cnt_q == TERMINAL);

   always_comb begin
      // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
      cnt_d = cnt_q;
      if (clr)       cnt_d = '0;
      else if (tick) cnt_d = '0;
      else if (run)  cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so all flops sample together.
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/decoder_nto2n_scan.sv
// Registered N-to-2^N decoder with 138-style three-pin enable, selectable polarity
// and a prescaled auto-scan mode that walks outputs 0..last and pulses wrap on return to 0.
module decoder_nto2n_scan
   import decoder_pkg::*;
#(
   parameter int N          = 3,
   parameter int DIV        = 4,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               g1,
   input  logic               g2a_n,
   input  logic               g2b_n,
   input  logic               mode,
   input  logic [N-1:0]       a,
   input  logic [N-1:0]       last,
   output logic [(1<<N)-1:0]  y,
   output logic [N-1:0]       idx,
   output logic               wrap
);

   localparam int              NOUT     = 1 << N;
   localparam logic [NOUT-1:0] INACTIVE = {NOUT{ACTIVE_LOW}};

   logic            en;
   logic            mode_q;
   logic            scan_start;
   logic            tick;
   logic [N-1:0]    idx_q, idx_d;
   logic [NOUT-1:0] y_q, y_d;
   logic            wrap_q, wrap_d;

   assign en         = g1 & ~g2a_n & ~g2b_n;
   assign scan_start = (mode == MODE_SCAN) && (mode_q == MODE_DIRECT);

   // Prescaler only advances while scanning and enabled; entering scan restarts it.
   scan_prescaler #(.DIV(DIV)) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   ((mode == MODE_DIRECT) || scan_start),
      .run   ((mode == MODE_SCAN) && en && !scan_start),
      .tick  (tick)
   );

   always_comb begin
      idx_d  = idx_q;
      wrap_d = 1'b0;
      if (mode == MODE_DIRECT) begin
         idx_d = a;
      end else if (scan_start) begin
         idx_d = '0;
      end else if (tick) begin
         if (idx_q >= last) begin
            idx_d  = '0;
            wrap_d = 1'b1;
         end else begin
            idx_d = idx_q + N'(1);
         end
      end
      // y is decoded from the next index so both registers always agree.
      y_d = NOUT'(decode(32'(idx_d), en, ACTIVE_LOW));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= MODE_DIRECT;
         idx_q  <= '0;
         y_q    <= INACTIVE;
         wrap_q <= 1'b0;
      end else begin
         mode_q <= mode;
         idx_q  <= idx_d;
         y_q    <= y_d;
         wrap_q <= wrap_d;
      end
   end

   assign y    = y_q;
   assign idx  = idx_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_nto2n_scan.sv
// Self-checking bench: two decoder instances (DIV=4 active-low, DIV=1 active-high) share
// stimulus and are compared every cycle against a cycle-level behavioural model.
module tb_decoder_nto2n_scan;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       g1    = 1'b0;
   logic       g2a_n = 1'b1;
   logic       g2b_n = 1'b1;
   logic       mode  = 1'b0;
   logic [2:0] a     = '0;
   logic [2:0] last  = '0;

   logic [7:0] y0, y1;
   logic [2:0] idx0, idx1;
   logic       wrap0, wrap1;

   int tests = 0;
   int fails = 0;

   // Model state per instance: current index, cycles since last step, previous mode.
   int         m_idx  [2];
   int         m_cnt  [2];
   logic       m_prev [2];
   logic       m_wrap [2];
   logic [7:0] m_y    [2];

   always #5 clk = ~clk;

   decoder_nto2n_scan #(.N(3), .DIV(4), .ACTIVE_LOW(1'b1)) dut0 (
      .clk(clk), .rst_n(rst_n), .g1(g1), .g2a_n(g2a_n), .g2b_n(g2b_n),
      .mode(mode), .a(a), .last(last), .y(y0), .idx(idx0), .wrap(wrap0)
   );

   decoder_nto2n_scan #(.N(3), .DIV(1), .ACTIVE_LOW(1'b0)) dut1 (
      .clk(clk), .rst_n(rst_n), .g1(g1), .g2a_n(g2a_n), .g2b_n(g2b_n),
      .mode(mode), .a(a), .last(last), .y(y1), .idx(idx1), .wrap(wrap1)
   );

   function automatic int div_of(input int k);
      return (k == 0) ? 4 : 1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_idx[k]  = 0;
         m_cnt[k]  = 0;
         m_prev[k] = 1'b0;
         m_wrap[k] = 1'b0;
         m_y[k]    = (k == 0) ? 8'hFF : 8'h00;
      end
   endtask

   task automatic model_edge();
      logic       en;
      logic [7:0] sel;
      en = g1 && !g2a_n && !g2b_n;
      for (int k = 0; k < 2; k++) begin
         m_wrap[k] = 1'b0;
         if (!mode) begin
            m_idx[k] = int'(a);
            m_cnt[k] = 0;
         end else if (!m_prev[k]) begin
            m_idx[k] = 0;
            m_cnt[k] = 0;
         end else if (en) begin
            if (m_cnt[k] == div_of(k) - 1) begin
               m_cnt[k] = 0;
               if (m_idx[k] >= int'(last)) begin
                  m_idx[k]  = 0;
                  m_wrap[k] = 1'b1;
               end else begin
                  m_idx[k] = m_idx[k] + 1;
               end
            end else begin
               m_cnt[k] = m_cnt[k] + 1;
            end
         end
         m_prev[k] = mode;
         sel = 8'd1 << m_idx[k];
         if (k == 0) m_y[k] = en ? ~sel : 8'hFF;
         else        m_y[k] = en ?  sel : 8'h00;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_y0"},    y0,    m_y[0]);
      check({tag, "_idx0"},  idx0,  m_idx[0]);
      check({tag, "_wrap0"}, wrap0, m_wrap[0]);
      check({tag, "_y1"},    y1,    m_y[1]);
      check({tag, "_idx1"},  idx1,  m_idx[1]);
      check({tag, "_wrap1"}, wrap1, m_wrap[1]);
   endtask

   // One clock: advance the model at the edge, then compare 1 time unit later.
   task automatic cyc(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin : stim
      logic [7:0] al_exp [8];
      logic [7:0] oh_exp [8];
      int         wraps;

      al_exp = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
      oh_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

      // Reset state
      model_reset();
      #12;
      check("rst_y0", y0, 8'hFF);
      check("rst_idx0", idx0, 0);
      check("rst_wrap0", wrap0, 0);
      check("rst_y1", y1, 8'h00);
      rst_n = 1'b1;

      // 1: direct decode sweep
      g1 = 1'b1; g2a_n = 1'b0; g2b_n = 1'b0; mode = 1'b0;
      for (int i = 0; i < 8; i++) begin
         a = 3'(i);
         cyc("t1");
         check("t1_y_const", y0, al_exp[i]);
         check("t1_idx_const", idx0, i);
      end

      // 2: each enable pin in turn
      a = 3'd5;
      g1 = 1'b0;               cyc("t2"); check("t2_g1_off", y0, 8'hFF);
      g1 = 1'b1; g2a_n = 1'b1; cyc("t2"); check("t2_g2a_off", y0, 8'hFF);
      g2a_n = 1'b0; g2b_n = 1'b1; cyc("t2"); check("t2_g2b_off", y0, 8'hFF);
      g2b_n = 1'b0;            cyc("t2"); check("t2_reen", y0, 8'hDF);

      // 3: full scan, last = 7, two complete periods
      last = 3'd7; mode = 1'b1; wraps = 0;
      for (int i = 0; i < 65; i++) begin
         cyc("t3");
         if (i == 0) check("t3_start_idx", idx0, 0);
         wraps += int'(wrap0);
      end
      check("t3_wrap_count", wraps, 2);

      // 4: lower last below the current index, then last = 0
      last = 3'd2;
      for (int i = 0; i < 8; i++) cyc("t4a");
      check("t4_at_idx2", idx0, 2);
      last = 3'd1;
      for (int i = 0; i < 4; i++) cyc("t4b");
      check("t4_lowered_idx", idx0, 0);
      check("t4_lowered_wrap", wrap0, 1);
      last = 3'd0; wraps = 0;
      for (int i = 0; i < 12; i++) begin
         cyc("t4c");
         wraps += int'(wrap0);
      end
      check("t4_last0_wraps", wraps, 3);
      check("t4_last0_idx", idx0, 0);

      // 5: disable mid-count, then resume
      last = 3'd7;
      for (int i = 0; i < 14; i++) cyc("t5a");
      check("t5_idx3", idx0, 3);
      g1 = 1'b0;
      for (int i = 0; i < 10; i++) cyc("t5b");
      check("t5_hold_y", y0, 8'hFF);
      check("t5_hold_idx", idx0, 3);
      g1 = 1'b1;
      cyc("t5c"); check("t5_resume1", idx0, 3);
      cyc("t5c"); check("t5_resume2", idx0, 4);

      // 6: asynchronous reset between edges
      @(posedge clk);
      model_edge();
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("t6_rst");
      check("t6_rst_y0", y0, 8'hFF);
      @(negedge clk);
      #2;
      rst_n = 1'b1;

      // 6: active-high, DIV = 1 instance: direct sweep then per-cycle scan
      mode = 1'b0;
      for (int i = 0; i < 8; i++) begin
         a = 3'(i);
         cyc("t6d");
         check("t6_onehot", y1, oh_exp[i]);
      end
      mode = 1'b1; last = 3'd7;
      for (int j = 0; j < 9; j++) begin
         cyc("t6s");
         check("t6_scan_idx", idx1, j % 8);
      end
      check("t6_scan_wrap", wrap1, 1);

      // Random phase against the model
      for (int i = 0; i < 400; i++) begin
         g1    = ($urandom_range(0, 9) != 0);
         g2a_n = ($urandom_range(0, 19) == 0);
         g2b_n = ($urandom_range(0, 19) == 0);
         a     = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 29) == 0) mode = ~mode;
         if ($urandom_range(0, 19) == 0) last = 3'($urandom_range(0, 7));
         cyc("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
